// File: rtl/retire_trace_buffer_pkg.sv
// ============================================================================
// retire_trace_buffer_pkg : shared state encodings, mode codes, record layout
// Revision 1.0
// ============================================================================
`default_nettype none

package retire_trace_buffer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_ARMED   = 3'd2,
      ST_POST    = 3'd3,
      ST_FROZEN  = 3'd4
   } state_t;

   localparam logic [1:0] MODE_RING = 2'b00;
   localparam logic [1:0] MODE_STOP = 2'b01;
   localparam logic [1:0] MODE_TRIG = 2'b10;

   localparam int REC_INSTR_W = 32;
   localparam int REC_RD_W    = 5;

   // Record layout, MSB first: {regwrite, rd, instr, pc, wdata}
   function automatic int rec_width(input int xlen);
      return 2 * xlen + REC_INSTR_W + REC_RD_W + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/retire_trace_buffer_ram.sv
// ============================================================================
// retire_trace_buffer_ram : DEPTH x WIDTH storage, sync write, async read
// Revision 1.0
// ============================================================================
`default_nettype none

module retire_trace_buffer_ram #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 166,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/retire_trace_buffer.sv
// ============================================================================
// retire_trace_buffer : retired-instruction trace capture (ring/stop/trigger)
// Revision 1.0
// ============================================================================
`default_nettype none

module retire_trace_buffer
   import retire_trace_buffer_pkg::*;
#(
   parameter int  XLEN      = 64,
   parameter int  DEPTH     = 16,
   parameter int  POST_TRIG = 8,
   localparam int REC_W     = rec_width(XLEN),
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             arm,
   input  logic [1:0]       mode,
   input  logic [XLEN-1:0]  trig_pc,
   input  logic             retire_valid,
   input  logic [XLEN-1:0]  pc,
   input  logic [31:0]      instr,
   input  logic [4:0]       rd,
   input  logic [XLEN-1:0]  wdata,
   input  logic             regwrite,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [REC_W-1:0] out_data,
   output logic [CNT_W-1:0] count,
   output logic             triggered,
   output logic             overflow,
   output logic             frozen
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] CNT_POST = CNT_W'(POST_TRIG);

   state_t           state, state_nxt;
   logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] post_cnt, post_cnt_nxt;
   logic             triggered_nxt, overflow_nxt;
   logic             stop_mode, stop_mode_nxt;

   logic             capturing;
   logic             wr_en;
   logic             full;
   logic             pop;
   logic [CNT_W-1:0] post_inc;
   logic [REC_W-1:0] record;

   assign capturing = (state == ST_CAPTURE) || (state == ST_ARMED) || (state == ST_POST);
   // arm takes priority: a retire in the arm cycle is dropped
   assign wr_en     = retire_valid && !arm && capturing;
   assign full      = (count == CNT_FULL);
   assign pop       = out_valid && out_ready;
   assign post_inc  = post_cnt + CNT_W'(1);
   assign record    = {regwrite, rd, instr, pc, wdata};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         post_cnt  <= '0;
         triggered <= 1'b0;
         overflow  <= 1'b0;
         stop_mode <= 1'b0;
      end else begin
         state     <= state_nxt;
         wr_ptr    <= wr_ptr_nxt;
         rd_ptr    <= rd_ptr_nxt;
         count     <= count_nxt;
         post_cnt  <= post_cnt_nxt;
         triggered <= triggered_nxt;
         overflow  <= overflow_nxt;
         stop_mode <= stop_mode_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      rd_ptr_nxt    = rd_ptr;
      count_nxt     = count;
      post_cnt_nxt  = post_cnt;
      triggered_nxt = triggered;
      overflow_nxt  = overflow;
      stop_mode_nxt = stop_mode;

      if (arm) begin
         wr_ptr_nxt    = '0;
         rd_ptr_nxt    = '0;
         count_nxt     = '0;
         post_cnt_nxt  = '0;
         triggered_nxt = 1'b0;
         overflow_nxt  = 1'b0;
         stop_mode_nxt = (mode == MODE_STOP);
         state_nxt     = (mode == MODE_TRIG) ? ST_ARMED : ST_CAPTURE;
      end else if (wr_en) begin
         wr_ptr_nxt = wr_ptr + PTR_W'(1);
         // Full buffer: overwrite the oldest entry and drag the read pointer along
         if (full) begin
            rd_ptr_nxt   = rd_ptr + PTR_W'(1);
            overflow_nxt = 1'b1;
         end else begin
            count_nxt = count + CNT_W'(1);
         end

         case (state)
            ST_CAPTURE: begin
               if (stop_mode && (count == CNT_LAST)) begin
                  state_nxt = ST_FROZEN;
               end
            end
            ST_ARMED: begin
               if (pc == trig_pc) begin
                  triggered_nxt = 1'b1;
                  post_cnt_nxt  = '0;
                  state_nxt     = (POST_TRIG == 0) ? ST_FROZEN : ST_POST;
               end
            end
            ST_POST: begin
               post_cnt_nxt = post_inc;
               if (post_inc == CNT_POST) begin
                  state_nxt = ST_FROZEN;
               end
            end
            default: begin
            end
         endcase
      end else if (pop) begin
         rd_ptr_nxt = rd_ptr + PTR_W'(1);
         count_nxt  = count - CNT_W'(1);
      end
   end

   assign frozen    = (state == ST_FROZEN);
   assign out_valid = frozen && (count != '0);

   retire_trace_buffer_ram #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (record),
      .raddr (rd_ptr),
      .rdata (out_data)
   );

endmodule

`default_nettype wire

// File: tb/tb_retire_trace_buffer.sv
// ============================================================================
// tb_retire_trace_buffer : directed self-checking bench, DEPTH=4 POST_TRIG=1
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_retire_trace_buffer;

   localparam int XLEN  = 64;
   localparam int DEPTH = 4;
   localparam int POST  = 1;
   localparam int REC_W = 2 * XLEN + 38;

   logic             clk = 1'b0;
   logic             reset;
   logic             arm;
   logic [1:0]       mode;
   logic [XLEN-1:0]  trig_pc;
   logic             retire_valid;
   logic [XLEN-1:0]  pc;
   logic [31:0]      instr;
   logic [4:0]       rd;
   logic [XLEN-1:0]  wdata;
   logic             regwrite;
   logic             out_valid;
   logic             out_ready;
   logic [REC_W-1:0] out_data;
   logic [2:0]       count;
   logic             triggered;
   logic             overflow;
   logic             frozen;

   int total = 0;
   int bad   = 0;

   retire_trace_buffer #(
      .XLEN      (XLEN),
      .DEPTH     (DEPTH),
      .POST_TRIG (POST)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .arm          (arm),
      .mode         (mode),
      .trig_pc      (trig_pc),
      .retire_valid (retire_valid),
      .pc           (pc),
      .instr        (instr),
      .rd           (rd),
      .wdata        (wdata),
      .regwrite     (regwrite),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .count        (count),
      .triggered    (triggered),
      .overflow     (overflow),
      .frozen       (frozen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // status vector {out_valid, triggered, overflow, frozen, count}
   function automatic logic [6:0] status();
      return {out_valid, triggered, overflow, frozen, count};
   endfunction

   function automatic logic [XLEN-1:0] out_pc();
      return out_data[2*XLEN-1:XLEN];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic retire(input logic [XLEN-1:0] p);
      retire_valid = 1'b1;
      pc           = p;
      instr        = 32'h0000_0013;
      rd           = 5'd0;
      wdata        = '0;
      regwrite     = 1'b0;
      tick();
      retire_valid = 1'b0;
   endtask

   task automatic do_arm(input logic [1:0] m);
      arm  = 1'b1;
      mode = m;
      tick();
      arm  = 1'b0;
   endtask

   initial begin
      reset = 1'b0; arm = 1'b0; mode = 2'b00; trig_pc = '0;
      retire_valid = 1'b0; pc = '0; instr = '0; rd = '0; wdata = '0;
      regwrite = 1'b0; out_ready = 1'b0;

      // Reset held low with activity on the inputs
      retire_valid = 1'b1;
      tick(); tick();
      chk("reset_status", 192'(status()), 192'(7'b0));
      retire_valid = 1'b0;
      reset = 1'b1;
      tick();

      // No arm: retires are ignored in IDLE
      for (int i = 0; i < 10; i++) retire(64'(4 * i));
      chk("idle_count", 192'(count), 192'(0));

      // Ring mode: 6 retires into a 4-deep buffer
      do_arm(2'b00);
      for (int i = 0; i < 6; i++) retire(64'(4 * i));
      chk("ring_status", 192'(status()), 192'({1'b0, 1'b0, 1'b1, 1'b0, 3'd4}));

      // Re-arm stop-on-full: flags flushed, then freeze after 4
      do_arm(2'b01);
      chk("rearm_status", 192'(status()), 192'(7'b0));
      for (int i = 0; i < 3; i++) retire(64'(4 * i));
      chk("stop_not_yet", 192'(frozen), 192'(0));
      retire(64'd12);
      chk("stop_status", 192'(status()), 192'({1'b1, 1'b0, 1'b0, 1'b1, 3'd4}));

      // Back-to-back pops with out_ready held high
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("stop_pop%0d", i), 192'(out_pc()), 192'(4 * i));
         tick();
      end
      out_ready = 1'b0;
      chk("drained_status", 192'(status()), 192'({1'b0, 1'b0, 1'b0, 1'b1, 3'd0}));
      retire(64'h40);
      chk("frozen_ignores_retire", 192'(count), 192'(0));

      // Trigger mode
      trig_pc = 64'h20;
      do_arm(2'b10);
      for (int i = 0; i < 5; i++) retire(64'h10 + 64'(4 * i));
      chk("trig_hit", 192'(status()), 192'({1'b0, 1'b1, 1'b1, 1'b0, 3'd4}));
      retire(64'h24);
      chk("trig_frozen", 192'(status()), 192'({1'b1, 1'b1, 1'b1, 1'b1, 3'd4}));
      retire(64'h28);
      chk("trig_post_drop", 192'(count), 192'(4));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("trig_pop%0d", i), 192'(out_pc()), 192'(64'h18 + 64'(4 * i)));
         tick();
      end
      out_ready = 1'b0;
      chk("trig_drained", 192'(out_valid), 192'(0));

      // arm coincident with a retire: the record is dropped
      retire_valid = 1'b1; pc = 64'h100;
      do_arm(2'b01);
      retire_valid = 1'b0;
      chk("arm_drops_retire", 192'(count), 192'(0));

      // arm while frozen with count=3 flushes the buffer
      for (int i = 0; i < 4; i++) retire(64'(4 * i));
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      chk("frozen_count3", 192'(count), 192'(3));
      do_arm(2'b00);
      chk("arm_flush", 192'(status()), 192'(7'b0));

      // Record field packing; mode change after arm must not matter
      do_arm(2'b01);
      mode = 2'b00;
      retire_valid = 1'b1;
      pc = 64'h8; instr = 32'h0050_0093; rd = 5'd1; wdata = 64'd5; regwrite = 1'b1;
      tick();
      retire_valid = 1'b0;
      for (int i = 1; i < 4; i++) retire(64'h8 + 64'(4 * i));
      chk("fields_frozen", 192'(frozen), 192'(1));
      chk("fields_record", 192'(out_data),
          192'({1'b1, 5'd1, 32'h0050_0093, 64'h8, 64'h5}));

      // Mode 11 decodes as ring
      do_arm(2'b11);
      for (int i = 0; i < 5; i++) retire(64'(4 * i));
      chk("mode11_ring", 192'(status()), 192'({1'b0, 1'b0, 1'b1, 1'b0, 3'd4}));

      // Asynchronous reset mid-capture
      retire_valid = 1'b1;
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      chk("async_reset", 192'(status()), 192'(7'b0));
      retire_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      chk("post_reset_idle", 192'(status()), 192'(7'b0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
